spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_if.sv | 28 ++
 rtl/spi_sclk_div.sv | 33 +++
 rtl/spi_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write controller.
// The register map matches the peripheral the controller talks to.
package spi_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_OUT_7_0   = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8  = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0   = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8  = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic       rw,
                                                          input logic [6:0] addr,
                                                          input logic [7:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_if.sv
// Host request/response handshake plus the four SPI pins of the controller.
// master = controller side, slave = host/peripheral side.
interface spi_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [6:0]  req_addr;
    logic [7:0]  req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        sclk;
    logic        copi;
    logic        cs;
    logic        cipo;

    modport master (
        input  req_valid, req_rw, req_addr, req_data, cipo,
        output req_ready, rsp_valid, rsp_data, busy, sclk, copi, cs
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_data, cipo,
        input  req_ready, rsp_valid, rsp_data, busy, sclk, copi, cs
    );

endinterface

// File: rtl/spi_sclk_div.sv
// Half-period tick generator: tick pulses once every CLK_DIV enabled cycles.
// clr restarts the count so every phase begins on a full half-period.
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI master sending one 16-bit {rw, addr, data} frame per host request, LSB first,
// and returning the 16 CIPO bits sampled on the rising sclk edges.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    spi_if.master bus
);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_controller: CLK_DIV must be within 2..255");
    end

    spi_state_e state, state_nxt;

    logic                  tick;
    logic                  ready_en;
    logic                  req_ready_int;
    logic                  accept;
    logic                  rise;
    logic                  fall;
    logic                  hold_done;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] rsp_data_q;
    logic                  rsp_valid_q;
    logic                  sclk_q;
    logic                  cs_q;

    // Every non-idle phase is a whole number of half-periods, so one free-running divider paces them all
    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    assign req_ready_int = (state == IDLE) && ready_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        hold_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid && req_ready_int) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    rise      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The low half-period after the last falling edge still belongs to SHIFT
                if (tick) begin
                    if (sclk_q) begin
                        fall = 1'b1;
                    end else if (bit_cnt == 5'(FRAME_BITS)) begin
                        state_nxt = HOLD;
                    end else begin
                        rise = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    hold_done = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // copi is tx_sr[0]; it is empty by the time the last bit has been shifted out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
        end else begin
            ready_en    <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                tx_sr   <= build_frame(bus.req_rw, bus.req_addr, bus.req_data);
                bit_cnt <= '0;
                sclk_q  <= 1'b0;
                cs_q    <= 1'b0;
            end
            if (rise) begin
                sclk_q               <= 1'b1;
                rx_sr[bit_cnt[3:0]]  <= bus.cipo;
            end
            if (fall) begin
                sclk_q  <= 1'b0;
                bit_cnt <= bit_cnt + 5'd1;
                tx_sr   <= {1'b0, tx_sr[FRAME_BITS-1:1]};
            end
            if (hold_done) begin
                cs_q        <= 1'b1;
                tx_sr       <= '0;
                rsp_data_q  <= rx_sr;
                rsp_valid_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.sclk      = sclk_q;
    assign bus.copi      = tx_sr[0];
    assign bus.cs        = cs_q;

endmodule
